// File: rtl/prog_load_pkg.sv
// Shared types and constants for the boot-time program loader.
package prog_load_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WRITE,
    DONE,
    ERROR
  } state_e;

  localparam logic [31:0] END_WORD_DEFAULT = 32'h0000_0FFF;
  localparam int          BYTES_PER_WORD   = 4;
  localparam int          BIDX_W           = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/prog_load_word_asm.sv
// Packs accepted UART bytes MSB-first into 32-bit words and flags the byte that
// completes a word.
module prog_load_word_asm
  import prog_load_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              byte_vld_i,
  input  logic [7:0]        byte_i,
  output logic [31:0]       word_o,
  output logic [31:0]       word_nxt_o,
  output logic [BIDX_W-1:0] byte_idx_o,
  output logic              word_valid_o
);

  logic [31:0]       shreg_q, shreg_d;
  logic [BIDX_W-1:0] idx_q, idx_d;

  always_comb begin
    shreg_d = shreg_q;
    idx_d   = idx_q;
    if (clr_i) begin
      shreg_d = '0;
      idx_d   = '0;
    end else if (byte_vld_i) begin
      shreg_d = {shreg_q[23:0], byte_i};
      idx_d   = idx_q + BIDX_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      shreg_q <= '0;
      idx_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
    end
  end

  // word_nxt_o lets the controller classify the word on the cycle its last byte
  // arrives, so the write request follows one cycle later.
  assign word_o       = shreg_q;
  assign word_nxt_o   = {shreg_q[23:0], byte_i};
  assign byte_idx_o   = idx_q;
  assign word_valid_o = byte_vld_i && !clr_i && (idx_q == BIDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/prog_load_ctrl.sv
// Boot-time program loader: UART bytes -> instruction memory words, core held in
// reset until the end marker. Define PROG_LOAD_TIMEOUT_EN for the inter-byte timeout.
module prog_load_ctrl
  import prog_load_pkg::*;
#(
  parameter int          ADDR_W         = 14,
  parameter int          MAX_WORDS      = 16384,
  parameter logic [31:0] END_WORD       = END_WORD_DEFAULT,
  parameter int          TIMEOUT_CYCLES = 100000
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              prog_en_i,
  input  logic              rx_valid_i,
  input  logic [7:0]        rx_data_i,
  output logic              rx_ready_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic              mem_gnt_i,
  output logic              core_rst_no,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [ADDR_W:0]   word_cnt_o
);

  state_e            state_q, state_d;
  logic [ADDR_W:0]   addr_q, addr_d;
  logic              accept;
  logic              word_valid;
  logic [31:0]       word, word_nxt;
  logic [BIDX_W-1:0] byte_idx;
  logic              timeout;

  assign rx_ready_o = (state_q == RECV);
  assign accept     = rx_valid_i && rx_ready_o;

  prog_load_word_asm u_word_asm (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .clr_i        (state_q == IDLE),
    .byte_vld_i   (accept),
    .byte_i       (rx_data_i),
    .word_o       (word),
    .word_nxt_o   (word_nxt),
    .byte_idx_o   (byte_idx),
    .word_valid_o (word_valid)
  );

`ifdef PROG_LOAD_TIMEOUT_EN
  logic [31:0] tmo_q, tmo_d;
  logic        tmo_run;

  // Only a partially received word is timed; idle time between words is free.
  assign tmo_run = (state_q == RECV) && (byte_idx != '0) && !accept;
  assign tmo_d   = tmo_run ? tmo_q + 32'd1 : 32'd0;
  assign timeout = tmo_run && (tmo_q == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) tmo_q <= '0;
    else         tmo_q <= tmo_d;
  end
`else
  logic unused_timeout;

  assign timeout        = 1'b0;
  assign unused_timeout = ^{byte_idx, (TIMEOUT_CYCLES == 0)};
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    mem_req_o   = 1'b0;
    mem_wdata_o = '0;
    core_rst_no = 1'b0;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    err_o       = 1'b0;
    case (state_q)
      IDLE: begin
        if (prog_en_i) begin
          state_d = RECV;
          addr_d  = '0;
        end
      end
      RECV: begin
        busy_o = 1'b1;
        if (word_valid) begin
          if (word_nxt == END_WORD)                           state_d = DONE;
          else if (addr_q == (ADDR_W+1)'(MAX_WORDS))          state_d = ERROR;
          else                                                state_d = WRITE;
        end else if (timeout) begin
          state_d = ERROR;
        end
      end
      WRITE: begin
        busy_o      = 1'b1;
        mem_req_o   = 1'b1;
        mem_wdata_o = word;
        if (mem_gnt_i) begin
          addr_d  = addr_q + (ADDR_W+1)'(1);
          state_d = RECV;
        end
      end
      DONE: begin
        done_o      = 1'b1;
        core_rst_no = 1'b1;
      end
      ERROR: begin
        err_o = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  assign mem_we_o   = mem_req_o;
  assign mem_addr_o = addr_q[ADDR_W-1:0];
  assign word_cnt_o = addr_q;

endmodule

// File: tb/tb_prog_load_ctrl.sv
// Directed bench for prog_load_ctrl: expected memory writes are queued by the
// stimulus and consumed by an independent write monitor.
module tb_prog_load_ctrl;

  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          prog_en_i = 1'b0;
  logic          rx_valid_i = 1'b0;
  logic [7:0]    rx_data_i = '0;
  logic          rx_ready_o;
  logic          mem_req_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [31:0]   mem_wdata_o;
  logic          mem_gnt_i = 1'b0;
  logic          core_rst_no, busy_o, done_o, err_o;
  logic [AW:0]   word_cnt_o;

  always #5 clk = ~clk;

  prog_load_ctrl #(
    .ADDR_W(AW), .MAX_WORDS(4), .END_WORD(32'h0000_0FFF), .TIMEOUT_CYCLES(50)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .prog_en_i(prog_en_i),
    .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i), .rx_ready_o(rx_ready_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .core_rst_no(core_rst_no),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .word_cnt_o(word_cnt_o)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t           exp_q[$];
  wr_t           got_wr;
  int            n_checks = 0;
  int            n_err = 0;
  int            req_cycles = 0;
  int            gnt_delay = 0;
  int            gnt_wait = 0;
  logic          prev_req = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic [31:0]   prev_data = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic wr_t mk(input int a, input logic [31:0] d);
    wr_t w;
    w.addr = AW'(a);
    w.data = d;
    return w;
  endfunction

  // Grant driver: holds off mem_gnt_i for gnt_delay cycles of a pending request.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst_ni && mem_req_o) begin
        if (gnt_wait >= gnt_delay) begin
          mem_gnt_i = 1'b1;
          gnt_wait  = 0;
        end else begin
          mem_gnt_i = 1'b0;
          gnt_wait++;
        end
      end else begin
        mem_gnt_i = 1'b0;
        gnt_wait  = 0;
      end
    end
  end

  // Write monitor / scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        prev_req = 1'b0;
      end else if (mem_req_o) begin
        req_cycles++;
        chk("rx_ready_in_write", rx_ready_o, 0);
        chk("we_eq_req", mem_we_o, 1);
        if (prev_req) begin
          chk("addr_stable", mem_addr_o, prev_addr);
          chk("data_stable", mem_wdata_o, prev_data);
        end
        if (mem_gnt_i) begin
          prev_req = 1'b0;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected",
                     mem_addr_o, mem_wdata_o);
          end else begin
            got_wr = exp_q.pop_front();
            chk("wr_addr", mem_addr_o, got_wr.addr);
            chk("wr_data", mem_wdata_o, got_wr.data);
          end
        end else begin
          prev_req  = 1'b1;
          prev_addr = mem_addr_o;
          prev_data = mem_wdata_o;
        end
      end else begin
        prev_req = 1'b0;
      end
    end
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: run exceeded 20000 cycles");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst_ni = 1'b0; prog_en_i = 1'b0; rx_valid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic start();
    rst_ni = 1'b1; prog_en_i = 1'b1;
    @(posedge clk);
    #1 prog_en_i = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    chk({tag, "_rx_ready"}, rx_ready_o, 0);
    chk({tag, "_req"}, mem_req_o, 0);
    chk({tag, "_we"}, mem_we_o, 0);
    chk({tag, "_addr"}, mem_addr_o, 0);
    chk({tag, "_wdata"}, mem_wdata_o, 0);
    chk({tag, "_core_rst_n"}, core_rst_no, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_err"}, err_o, 0);
    chk({tag, "_cnt"}, word_cnt_o, 0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit got = 1'b0;
    rx_valid_i = 1'b1;
    rx_data_i  = b;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      if (rx_ready_o) got = 1'b1;
    end
    @(posedge clk);
    #1 rx_valid_i = 1'b0;
    if (!got) begin
      n_checks++;
      n_err++;
      $display("FAIL byte_accept: byte 0x%0h not accepted, required within 200 cycles", b);
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8]);
  endtask

  task automatic wait_end();
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (done_o || err_o) break;
    end
  endtask

  task automatic check_status(input string tag, input logic done, input logic err,
                              input int cnt);
    chk({tag, "_done"}, done_o, done);
    chk({tag, "_err"}, err_o, err);
    chk({tag, "_core_rst_n"}, core_rst_no, done);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_rx_ready"}, rx_ready_o, 0);
    chk({tag, "_cnt"}, word_cnt_o, cnt);
    chk({tag, "_pending"}, exp_q.size(), 0);
  endtask

  int r0;

  initial begin
    // Basic program, zero-wait grant.
    do_reset();
    check_reset_outputs("rst");
    gnt_delay = 0;
    exp_q.push_back(mk(0, 32'h0000_0013));
    exp_q.push_back(mk(1, 32'h0050_0093));
    start();
    send_word(32'h0000_0013);
    send_word(32'h0050_0093);
    send_word(32'h0000_0FFF);
    wait_end();
    check_status("basic", 1'b1, 1'b0, 2);

    // Same program with a 5-cycle grant delay.
    do_reset();
    gnt_delay = 5;
    exp_q.push_back(mk(0, 32'h0000_0013));
    exp_q.push_back(mk(1, 32'h0050_0093));
    start();
    send_word(32'h0000_0013);
    send_word(32'h0050_0093);
    send_word(32'h0000_0FFF);
    wait_end();
    check_status("slowgnt", 1'b1, 1'b0, 2);
    gnt_delay = 0;

    // Overflow: five data words into a four-word memory.
    do_reset();
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(i, 32'hA000_0000 + 32'(i)));
    r0 = req_cycles;
    start();
    for (int i = 0; i < 5; i++) send_word(32'hA000_0000 + 32'(i));
    wait_end();
    check_status("ovf", 1'b0, 1'b1, 4);
    chk("ovf_req_cycles", req_cycles - r0, 4);

    // Exactly full memory then end marker.
    do_reset();
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(i, 32'h5A5A_0000 + 32'(i)));
    start();
    for (int i = 0; i < 4; i++) send_word(32'h5A5A_0000 + 32'(i));
    send_word(32'h0000_0FFF);
    wait_end();
    check_status("full", 1'b1, 1'b0, 4);

    // End marker as the very first word.
    do_reset();
    r0 = req_cycles;
    start();
    send_word(32'h0000_0FFF);
    wait_end();
    check_status("empty", 1'b1, 1'b0, 0);
    chk("empty_req_cycles", req_cycles - r0, 0);

    // Reset in the middle of a word, then a fresh stream from address 0.
    do_reset();
    exp_q.push_back(mk(0, 32'h1111_2222));
    exp_q.push_back(mk(1, 32'h3333_4444));
    start();
    send_word(32'h1111_2222);
    send_word(32'h3333_4444);
    send_byte(8'hAA);
    send_byte(8'hBB);
    rst_ni = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("midrst");
    exp_q.push_back(mk(0, 32'hDEAD_BEEF));
    start();
    send_word(32'hDEAD_BEEF);
    send_word(32'h0000_0FFF);
    wait_end();
    check_status("restart", 1'b1, 1'b0, 1);

    // Long idle at a word boundary never errors.
    do_reset();
    exp_q.push_back(mk(0, 32'hCAFE_F00D));
    start();
    send_word(32'hCAFE_F00D);
    repeat (60) @(posedge clk);
    @(negedge clk);
    chk("boundary_idle_err", err_o, 0);
    chk("boundary_idle_busy", busy_o, 1);
    chk("boundary_idle_cnt", word_cnt_o, 1);
`ifdef PROG_LOAD_TIMEOUT_EN
    // Partial word stalled: error exactly 50 cycles after the last byte.
    send_byte(8'h12);
    send_byte(8'h34);
    repeat (49) @(posedge clk);
    @(negedge clk);
    chk("tmo_cycle49_err", err_o, 0);
    @(posedge clk);
    @(negedge clk);
    chk("tmo_cycle50_err", err_o, 1);
    chk("tmo_core_rst_n", core_rst_no, 0);
    chk("tmo_cnt", word_cnt_o, 1);
`endif

    repeat (5) @(posedge clk);
    chk("final_pending", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
